// File: rtl/decode_pipe_pkg.sv
// Shared decode definitions: opcodes, immediate formats and the
// decoded-control bundle carried from decode into the ID/EX register.
package decode_pipe_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_ANDI = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_LI   = 4'h9;
    localparam logic [3:0] OP_LIU  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IMM5,
        IMM8,
        DISP11
    } imm_fmt_e;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic halt;
    } ctrl_t;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic       rs_used;
        logic       rt_used;
        logic       zext;
        imm_fmt_e   fmt;
        ctrl_t      ctrl;
    } dec_t;

    // Fields: op[15:12] A[11:9] B[8:6] C[5:3]; rd=A, rs=B, rt=C (A for stores).
    function automatic dec_t decode(input logic [15:0] instr);
        dec_t d;
        d    = '0;
        d.rd = instr[11:9];
        d.rs = instr[8:6];
        d.rt = instr[5:3];
        case (instr[15:12])
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                d.rs_used = 1'b1;
                d.rt_used = 1'b1;
                d.ctrl.regwrite = 1'b1;
            end
            OP_ADDI: begin
                d.rs_used = 1'b1;
                d.ctrl.regwrite = 1'b1;
            end
            OP_ANDI: begin
                d.rs_used = 1'b1;
                d.zext = 1'b1;
                d.ctrl.regwrite = 1'b1;
            end
            OP_LD: begin
                d.rs_used = 1'b1;
                d.ctrl.regwrite = 1'b1;
                d.ctrl.memread = 1'b1;
                d.ctrl.memtoreg = 1'b1;
            end
            OP_ST: begin
                d.rt = instr[11:9];
                d.rs_used = 1'b1;
                d.rt_used = 1'b1;
                d.ctrl.memwrite = 1'b1;
            end
            OP_LI: begin
                d.fmt = IMM8;
                d.ctrl.regwrite = 1'b1;
            end
            OP_LIU: begin
                d.fmt = IMM8;
                d.zext = 1'b1;
                d.ctrl.regwrite = 1'b1;
            end
            OP_JMP:  d.fmt = DISP11;
            OP_HALT: d.ctrl.halt = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// Fetch, writeback/kill and execute-side signals of the decode stage.
interface decode_pipe_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
);
    localparam int RAW = $clog2(NREG);

    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic [DATA_W-1:0] in_pc;
    logic              flush;
    logic              wb_en;
    logic [RAW-1:0]    wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              kill_en;
    logic [RAW-1:0]    kill_reg;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_pc;
    logic [15:0]       out_instr;
    logic [RAW-1:0]    out_rd;
    logic              out_regwrite;
    logic              out_memread;
    logic              out_memwrite;
    logic              out_memtoreg;
    logic              out_halt;
    logic              err;

    modport master (
        output in_valid, in_instr, in_pc, flush,
        output wb_en, wb_reg, wb_data, kill_en, kill_reg,
        output out_ready,
        input  in_ready, out_valid, out_rs_data, out_rt_data,
        input  out_imm, out_pc, out_instr, out_rd,
        input  out_regwrite, out_memread, out_memwrite,
        input  out_memtoreg, out_halt, err
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush,
        input  wb_en, wb_reg, wb_data, kill_en, kill_reg,
        input  out_ready,
        output in_ready, out_valid, out_rs_data, out_rt_data,
        output out_imm, out_pc, out_instr, out_rd,
        output out_regwrite, out_memread, out_memwrite,
        output out_memtoreg, out_halt, err
    );

endinterface

// File: rtl/decode_scoreboard.sv
// Per-register outstanding-write counters, RAW/overflow hazard
// detection and sticky underflow/overflow error.
module decode_scoreboard #(
    parameter int NREG  = 8,
    parameter int CNT_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_i,
    input  logic                    regwrite_i,
    input  logic                    rs_used_i,
    input  logic                    rt_used_i,
    input  logic [$clog2(NREG)-1:0] rd_i,
    input  logic [$clog2(NREG)-1:0] rs_i,
    input  logic [$clog2(NREG)-1:0] rt_i,
    input  logic                    wb_en_i,
    input  logic [$clog2(NREG)-1:0] wb_reg_i,
    input  logic                    kill_en_i,
    input  logic [$clog2(NREG)-1:0] kill_reg_i,
    output logic                    haz_o,
    output logic                    err_o
);
    localparam int RAW = $clog2(NREG);
    localparam int SW  = CNT_W + 2;
    localparam logic signed [SW-1:0] CMAX = SW'((1 << CNT_W) - 1);

    logic [CNT_W-1:0]     cnt_q [NREG];
    logic [CNT_W-1:0]     cnt_d [NREG];
    logic signed [SW-1:0] post_dec [NREG];
    logic signed [SW-1:0] net [NREG];
    logic [NREG-1:0]      pend;
    logic                 bad;
    logic                 err_q;
    logic                 err_d;

    // Net of issue, writeback and kill; out-of-range results flag an error.
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            post_dec[i] = $signed(SW'(cnt_q[i]))
                - $signed(SW'(wb_en_i && wb_reg_i == RAW'(i)))
                - $signed(SW'(kill_en_i && kill_reg_i == RAW'(i)));
            net[i] = post_dec[i]
                + $signed(SW'(issue_i && regwrite_i && rd_i == RAW'(i)));
            pend[i]  = post_dec[i] != '0;
            cnt_d[i] = net[i][CNT_W-1:0];
            if (net[i][SW-1]) begin
                bad = 1'b1;
                cnt_d[i] = '0;
            end else if (net[i] > CMAX) begin
                bad = 1'b1;
                cnt_d[i] = '1;
            end
        end
    end

    assign err_d = err_q | bad;

    assign haz_o = (rs_used_i && pend[rs_i])
                || (rt_used_i && pend[rt_i])
                || (regwrite_i && (&cnt_q[rd_i]));

    assign err_o = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// Pipelined decode: control decode, bypassing register file,
// scoreboard stall and a registered ID/EX output stage.
module decode_pipe #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int CNT_W  = 2
) (
    input logic          clk,
    input logic          rst,
    decode_pipe_if.slave bus
);
    import decode_pipe_pkg::*;

    localparam int RAW = $clog2(NREG);

    typedef struct packed {
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [15:0]       instr;
        logic [RAW-1:0]    rd;
        ctrl_t             ctrl;
    } idex_t;

    dec_t              dec;
    logic [RAW-1:0]    rs;
    logic [RAW-1:0]    rt;
    logic [RAW-1:0]    rd;
    logic [DATA_W-1:0] imm;
    logic              sx;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] rf_q [NREG];
    logic              haz;
    logic              sb_err;
    logic              in_ready;
    logic              issue;
    idex_t             idex_q;
    idex_t             idex_d;
    logic              valid_q;
    logic              valid_d;
    logic              halted_q;
    logic              halted_d;

    assign dec = decode(bus.in_instr);
    assign rs  = RAW'(dec.rs);
    assign rt  = RAW'(dec.rt);
    assign rd  = RAW'(dec.rd);

    always_comb begin
        sx  = 1'b0;
        imm = '0;
        unique case (dec.fmt)
            IMM5: begin
                sx  = bus.in_instr[4] & ~dec.zext;
                imm = {{(DATA_W-5){sx}}, bus.in_instr[4:0]};
            end
            IMM8: begin
                sx  = bus.in_instr[7] & ~dec.zext;
                imm = {{(DATA_W-8){sx}}, bus.in_instr[7:0]};
            end
            DISP11: imm = {{(DATA_W-11){bus.in_instr[10]}}, bus.in_instr[10:0]};
            default: imm = '0;
        endcase
    end

    // Same-cycle writeback is forwarded to the read ports.
    assign rs_data = (bus.wb_en && bus.wb_reg == rs) ? bus.wb_data : rf_q[rs];
    assign rt_data = (bus.wb_en && bus.wb_reg == rt) ? bus.wb_data : rf_q[rt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (bus.wb_en) begin
            rf_q[bus.wb_reg] <= bus.wb_data;
        end
    end

    decode_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .issue_i    (issue),
        .regwrite_i (dec.ctrl.regwrite),
        .rs_used_i  (dec.rs_used),
        .rt_used_i  (dec.rt_used),
        .rd_i       (rd),
        .rs_i       (rs),
        .rt_i       (rt),
        .wb_en_i    (bus.wb_en),
        .wb_reg_i   (bus.wb_reg),
        .kill_en_i  (bus.kill_en),
        .kill_reg_i (bus.kill_reg),
        .haz_o      (haz),
        .err_o      (sb_err)
    );

    assign in_ready = !haz && (!valid_q || bus.out_ready) && !halted_q;
    assign issue    = bus.in_valid && in_ready && !bus.flush;
    assign halted_d = halted_q | (issue & dec.ctrl.halt);

    always_comb begin
        idex_d  = idex_q;
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (issue) begin
            valid_d        = 1'b1;
            idex_d.rs_data = rs_data;
            idex_d.rt_data = rt_data;
            idex_d.imm     = imm;
            idex_d.pc      = bus.in_pc;
            idex_d.instr   = bus.in_instr;
            idex_d.rd      = rd;
            idex_d.ctrl    = dec.ctrl;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            idex_q   <= idex_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = valid_q;
    assign bus.out_rs_data  = idex_q.rs_data;
    assign bus.out_rt_data  = idex_q.rt_data;
    assign bus.out_imm      = idex_q.imm;
    assign bus.out_pc       = idex_q.pc;
    assign bus.out_instr    = idex_q.instr;
    assign bus.out_rd       = idex_q.rd;
    assign bus.out_regwrite = idex_q.ctrl.regwrite;
    assign bus.out_memread  = idex_q.ctrl.memread;
    assign bus.out_memwrite = idex_q.ctrl.memwrite;
    assign bus.out_memtoreg = idex_q.ctrl.memtoreg;
    assign bus.out_halt     = idex_q.ctrl.halt;
    assign bus.err          = sb_err;

endmodule
